stream_downsizer: RTL and testbench

- Width-downsizing stream converter with ready/valid handshakes on both sides.
- Accepts one wide beat of T_DATA_RATIO words per handshake and emits the words one per handshake on a narrow master port, index 0 first.
- Propagates packet boundaries: s_last_i on an input beat marks the final word of that beat with m_last_o.
- Sits between a wide producer and a narrow consumer inside a streaming datapath.

---
 rtl/stream_downsizer.sv | 84 ++++++++
 tb/tb_stream_downsizer.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_downsizer.sv
// Width-downsizing stream converter: accepts one wide beat of T_DATA_RATIO
// words and replays it one word per handshake on the narrow side, index 0
// first. The last flag of a wide beat is attached only to its final word.
module stream_downsizer #(
  parameter int T_DATA_WIDTH = 8,
  parameter int T_DATA_RATIO = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,  // active-high despite the name
  input  logic [T_DATA_WIDTH-1:0] s_data_i [T_DATA_RATIO-1:0],
  input  logic                    s_last_i,
  input  logic                    s_valid_i,
  output logic                    s_ready_o,
  output logic [T_DATA_WIDTH-1:0] m_data_o,
  output logic                    m_last_o,
  output logic                    m_valid_o,
  input  logic                    m_ready_i
);

  localparam int CNT_W = (T_DATA_RATIO > 1) ? $clog2(T_DATA_RATIO) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(T_DATA_RATIO - 1);

  logic [T_DATA_WIDTH-1:0] word_q [T_DATA_RATIO-1:0];
  logic                    last_q;
  logic                    busy_q;
  logic [CNT_W-1:0]        cnt_q;

  logic at_last;
  logic s_hs;
  logic m_hs;

  // Handshake qualifiers; s_ready_o looks through to m_ready_i so the next
  // beat loads in the same cycle the final word leaves (no bubble).
  always_comb begin
    at_last   = (cnt_q == LAST_IDX);
    s_ready_o = !rst_n && (!busy_q || (m_ready_i && at_last));
    s_hs      = s_valid_i && s_ready_o;
    m_hs      = busy_q && m_ready_i;
  end

  // Control state: busy flag, word index and packet-end flag of the held beat.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      last_q <= 1'b0;
    end else if (s_hs) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      busy_q <= 1'b1;
      cnt_q  <= '0;
      last_q <= s_last_i;
    end else if (m_hs) begin
      if (!at_last) begin
        cnt_q <= cnt_q + 1'b1;
      end else begin
        busy_q <= 1'b0;
      end
    end
  end

  // Word buffer: captured on the input handshake only.
  // NOTE: the data buffer has no reset; busy_q gates every read, so its
  // contents are don't-care until the first beat is loaded.
  always_ff @(posedge clk) begin
    if (s_hs) begin
      word_q <= s_data_i;
    end
  end

  // Output drive: data forced to zero when idle, last only on the final word.
  always_comb begin
    // NOTE: defaults first so no path leaves an output unassigned (no latch).
    m_valid_o = 1'b0;
    m_data_o  = '0;
    m_last_o  = 1'b0;
    if (busy_q) begin
      m_valid_o = 1'b1;
      m_data_o  = word_q[cnt_q];
      m_last_o  = last_q && at_last;
    end
  end

endmodule

// File: tb/tb_stream_downsizer.sv
// Directed and randomized bench for stream_downsizer (8-bit words, ratio 4).
// Inputs change 1 time unit after the rising edge; outputs are sampled on the
// falling edge. A monitor compares every output handshake to a queue of
// expected words built from the beats the bench itself drives.
module tb_stream_downsizer;

  typedef logic [7:0] beat_t [3:0];
  typedef struct packed {
    logic       last;
    logic [7:0] data;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic [7:0] s_data [3:0];
  logic       s_last;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] m_data;
  logic       m_last;
  logic       m_valid;
  logic       m_ready;

  int   total = 0;
  int   bad   = 0;
  int   out_words = 0;
  int   out_lasts = 0;
  exp_t exp_q [$];

  stream_downsizer #(.T_DATA_WIDTH(8), .T_DATA_RATIO(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_data_i  (s_data),
    .s_last_i  (s_last),
    .s_valid_i (s_valid),
    .s_ready_o (s_ready),
    .m_data_o  (m_data),
    .m_last_o  (m_last),
    .m_valid_o (m_valid),
    .m_ready_i (m_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic beat_t mk(input logic [7:0] a, b, c, d);
    beat_t w;
    w[0] = a; w[1] = b; w[2] = c; w[3] = d;
    return w;
  endfunction

  task automatic push_exp(input beat_t w, input logic l);
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      e.data = w[i];
      e.last = l && (i == 3);
      exp_q.push_back(e);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 right after the accepting edge.
  task automatic drive_beat(input beat_t w, input logic l, input int budget);
    int n = 0;
    s_data  = w;
    s_last  = l;
    s_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (s_ready) begin
        push_exp(w, l);
        @(posedge clk); #1;
        s_valid = 1'b0;
        return;
      end
      n++;
      if (n >= budget) begin
        check("accept_timeout", 0, 1);
        s_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic drain(input string tag, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check(tag, exp_q.size(), 0);
  endtask

  // Scoreboard monitor: every accepted output word must match the queue head.
  always @(negedge clk) begin
    if (m_valid && m_ready) begin
      exp_t e;
      out_words++;
      if (m_last) out_lasts++;
      if (exp_q.size() == 0) begin
        check("extra_word", {23'd0, m_last, m_data}, 32'hDEAD);
      end else begin
        e = exp_q.pop_front();
        check("word_data", m_data, e.data);
        check("word_last", m_last, e.last);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    beat_t w;
    int    idx;
    int    nlast;
    int    base_words;
    int    base_lasts;
    logic  pat [7];

    rst_n   = 1'b1;
    s_data  = mk(8'h00, 8'h00, 8'h00, 8'h00);
    s_last  = 1'b0;
    s_valid = 1'b0;
    m_ready = 1'b0;

    // Reset state, before any clock edge.
    #3;
    check("rst_valid", m_valid, 0);
    check("rst_last",  m_last,  0);
    check("rst_data",  m_data,  0);
    check("rst_ready", s_ready, 0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    check("ready_after_rst", s_ready, 1);

    // Test 1: single last beat, per-cycle timing.
    @(posedge clk); #1;
    w = mk(8'h11, 8'h22, 8'h33, 8'h44);
    s_data = w; s_last = 1'b1; s_valid = 1'b1; m_ready = 1'b1;
    push_exp(w, 1'b1);
    @(posedge clk); #1;
    s_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t1_valid", m_valid, 1);
      check("t1_data",  m_data,  8'h11 * (i + 1));
      check("t1_last",  m_last,  (i == 3));
      check("t1_ready", s_ready, (i == 3));
    end
    @(negedge clk);
    check("t1_idle", m_valid, 0);
    @(posedge clk); #1;
    drain("t1_drain", 10);

    // Test 2: back-to-back beats without gaps.
    w = mk(8'd1, 8'd2, 8'd3, 8'd4);
    s_data = w; s_last = 1'b0; s_valid = 1'b1;
    push_exp(w, 1'b0);
    @(negedge clk);
    check("t2_ready_idle", s_ready, 1);
    @(posedge clk); #1;
    w = mk(8'd5, 8'd6, 8'd7, 8'd8);
    s_data = w; s_last = 1'b1;
    push_exp(w, 1'b1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("t2_valid", m_valid, 1);
      check("t2_data",  m_data,  i + 1);
      if (i < 4) check("t2_ready", s_ready, (i == 3));
      @(posedge clk); #1;
      if (i == 3) s_valid = 1'b0;
    end
    drain("t2_drain", 10);

    // Test 3: backpressure pattern 1,0,0,1,1,0,1.
    pat[0] = 1; pat[1] = 0; pat[2] = 0; pat[3] = 1; pat[4] = 1; pat[5] = 0; pat[6] = 1;
    m_ready = 1'b0;
    drive_beat(mk(8'hA0, 8'hA1, 8'hA2, 8'hA3), 1'b0, 20);
    idx = 0;
    for (int k = 0; k < 7; k++) begin
      m_ready = pat[k];
      @(negedge clk);
      check("t3_valid", m_valid, 1);
      check("t3_data",  m_data,  8'hA0 + idx);
      if (pat[k]) idx++;
      @(posedge clk); #1;
    end
    m_ready = 1'b1;
    @(negedge clk);
    check("t3_idle", m_valid, 0);
    @(posedge clk); #1;
    drain("t3_drain", 10);

    // Test 4: input noise while the beat is being replayed.
    drive_beat(mk(8'h31, 8'h32, 8'h33, 8'h34), 1'b1, 20);
    for (int i = 0; i < 4; i++) begin
      s_data = mk(8'hFF, 8'hFF, 8'hFF, 8'hFF);
      s_last = i[0];
      @(negedge clk);
      check("t4_data", m_data, 8'h31 + i);
      @(posedge clk); #1;
    end
    s_data = mk(8'h00, 8'h00, 8'h00, 8'h00);
    s_last = 1'b0;
    drain("t4_drain", 10);

    // Test 5: reset after two of four words, then a fresh beat.
    drive_beat(mk(8'h51, 8'h52, 8'h53, 8'h54), 1'b1, 20);
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    @(posedge clk); #1;
    #2;
    rst_n = 1'b1;
    #1;
    check("t5_rst_valid", m_valid, 0);
    check("t5_rst_last",  m_last,  0);
    check("t5_rst_data",  m_data,  0);
    check("t5_rst_ready", s_ready, 0);
    exp_q.delete();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    drive_beat(mk(8'd9, 8'd8, 8'd7, 8'd6), 1'b0, 20);
    drain("t5_drain", 10);

    // Test 6: random beats with heavy output backpressure.
    base_words = out_words;
    base_lasts = out_lasts;
    nlast = 0;
    begin
      bit rnd_done;
      rnd_done = 1'b0;
      fork
        begin
          for (int b = 0; b < 200; b++) begin
            beat_t rw;
            logic  rl;
            while ($urandom_range(9) >= 8) begin
              @(posedge clk); #1;
            end
            for (int i = 0; i < 4; i++) rw[i] = 8'($urandom_range(255));
            rl = 1'($urandom_range(1));
            if (rl) nlast++;
            drive_beat(rw, rl, 3000);
          end
          rnd_done = 1'b1;
        end
        begin
          while (!rnd_done) begin
            m_ready = ($urandom_range(9) == 0);
            @(posedge clk); #1;
          end
        end
      join
    end
    m_ready = 1'b1;
    drain("t6_drain", 5000);
    check("t6_words", out_words - base_words, 800);
    check("t6_lasts", out_lasts - base_lasts, nlast);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
